muldiv_iter: RTL
================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter: DWIDTH, default 32, operand/result width; legal values are even and >= 4.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: nReset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: MDFunc  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: A  input  DWIDTH  rs1 operand (dividend for divide ops).
REQ-007 SHALL have port: B  input  DWIDTH  rs2 operand (divisor for divide ops).
REQ-008 SHALL have port: MDOut  output  DWIDTH  registered result.
REQ-009 SHALL have port: Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: Done  output  1  one-cycle pulse; MDOut valid in that cycle.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DIVIDE, FINISH; Done = (state == FINISH); Busy = (state != IDLE).
REQ-012 SHALL, on a rising edge in IDLE with Start=1, latch A, B and MDFunc into internal registers; A, B, MDFunc may change afterwards without effect.
REQ-013 SHALL go IDLE->CALC for MDFunc 000-011, and for 100-111 when B=0 or (signed op, A=most-negative, B=all-ones).
REQ-014 SHALL go IDLE->DIVIDE for all other divide ops.
REQ-015 SHALL go CALC->FINISH after one cycle, loading MDOut; multiply latency = 2 edges from the Start-sampling edge to Done high.
REQ-016 SHALL remain in DIVIDE for exactly DWIDTH cycles using restoring radix-2 on operand magnitudes, one quotient bit per cycle, then enter FINISH, loading MDOut; divide latency = DWIDTH+1 edges (33 at DWIDTH=32).
REQ-017 SHALL go FINISH->IDLE unconditionally after one cycle; Start in CALC, DIVIDE or FINISH is ignored and not queued.
REQ-018 SHALL accept Start in the cycle after FINISH; back-to-back ops are separated by at least one IDLE cycle.
REQ-019 SHALL compute MUL as low DWIDTH bits, and MULH/MULHSU/MULHU as high DWIDTH bits of the 2*DWIDTH product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-020 SHALL round signed quotient toward zero; signed remainder takes dividend's sign; magnitude negation is applied on entry to FINISH.
REQ-021 SHALL, when B=0, return quotient all-ones (DIV, DIVU) and remainder = A (REM, REMU).
REQ-022 SHALL, for signed overflow (A=most-negative, B=-1), return DIV = A and REM = 0.
REQ-023 SHALL hold MDOut stable from FINISH until the next entry to FINISH.
REQ-024 SHALL contain no combinational path from inputs to MDOut, Busy or Done.

Reset
REQ-025 SHALL, when nReset=0, asynchronously force state=IDLE, MDOut=0, Busy=0, Done=0, and clear the iteration counter and operand registers.
REQ-026 SHALL abandon an in-progress operation when reset asserts mid-operation, without producing Done; the first Start after nReset rises is serviced normally.

Verification
REQ-027 SHALL verify multiply at DWIDTH=32:
- MUL 7 * 0xFFFFFFFD -> MDOut 0xFFFFFFEB, Done 2 edges after Start.
- MULH 0x80000000 * 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 SHALL verify divide at DWIDTH=32:
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
- REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
- DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Done exactly 33 edges after Start; Busy high throughout.
REQ-029 SHALL verify special cases:
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- All four complete with 2-edge latency.
REQ-030 SHALL verify Start pulsed with different operands at cycles 5 and 20 of a DIVU -> ignored; single Done with the original result; MDOut unchanged until that Done.
REQ-031 SHALL verify nReset low at cycle 10 of a DIV -> Busy=0, Done=0, MDOut=0 immediately; no Done follows; the next DIVU 9 / 3 returns 3.
REQ-032 SHALL verify random regression of 10k ops per MDFunc at DWIDTH=32 and DWIDTH=8 against a reference model, including operands 0, 1, -1, most-negative and most-positive.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: multiplies finish in 2 cycles,
// divides use DWIDTH restoring radix-2 iterations on operand magnitudes.
`timescale 1ns/1ps
module muldiv_iter #(
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              Start,
  input  logic [2:0]        MDFunc,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  output logic [DWIDTH-1:0] MDOut,
  output logic              Busy,
  output logic              Done
);

  localparam int CW = $clog2(DWIDTH + 1);
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DIVIDE, FINISH} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] a_r, b_r;
  logic [2:0]        func_r;
  logic [DWIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [CW-1:0]     cnt;

  function automatic logic [DWIDTH-1:0] neg_if(input logic [DWIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Multiply results plus the divide-by-zero and signed-overflow shortcuts.
  function automatic logic [DWIDTH-1:0] calc_result(input logic [2:0] f,
                                                    input logic [DWIDTH-1:0] a,
                                                    input logic [DWIDTH-1:0] b);
    logic              sa, sb;
    logic [2*DWIDTH-1:0] ax, bx, p;
    sa = (f != 3'b011);
    sb = (f == 3'b000) || (f == 3'b001);
    ax = {{DWIDTH{sa & a[DWIDTH-1]}}, a};
    bx = {{DWIDTH{sb & b[DWIDTH-1]}}, b};
    p  = ax * bx;
    if (!f[2])
      return (f == 3'b000) ? p[DWIDTH-1:0] : p[2*DWIDTH-1:DWIDTH];
    else if (b == '0)
      return f[1] ? a : '1;
    else
      return f[1] ? '0 : a;
  endfunction

  logic              in_div, in_signed, in_special;
  logic              last_iter;
  logic [DWIDTH:0]   shifted, trial;
  logic              q_bit;
  logic [DWIDTH-1:0] rem_step, quo_step;
  logic              div_signed, q_neg, r_neg;
  logic [DWIDTH-1:0] div_result;

  always_comb begin
    in_div     = MDFunc[2];
    in_signed  = ~MDFunc[0];
    in_special = (B == '0) || (in_signed && (A == MOST_NEG) && (B == '1));
    last_iter  = (cnt == CW'(DWIDTH - 1));
    shifted    = {rem_r, quo_r[DWIDTH-1]};
    trial      = shifted - {1'b0, dvs_r};
    q_bit      = ~trial[DWIDTH];
    rem_step   = q_bit ? trial[DWIDTH-1:0] : shifted[DWIDTH-1:0];
    quo_step   = {quo_r[DWIDTH-2:0], q_bit};
    div_signed = ~func_r[0];
    q_neg      = div_signed & (a_r[DWIDTH-1] ^ b_r[DWIDTH-1]);
    r_neg      = div_signed & a_r[DWIDTH-1];
    div_result = func_r[1] ? neg_if(rem_step, r_neg) : neg_if(quo_step, q_neg);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = (in_div && !in_special) ? DIVIDE : CALC;
      CALC:    state_nxt = FINISH;
      DIVIDE:  if (last_iter) state_nxt = FINISH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == FINISH);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      a_r    <= '0;
      b_r    <= '0;
      func_r <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      cnt    <= '0;
      MDOut  <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          a_r    <= A;
          b_r    <= B;
          func_r <= MDFunc;
          rem_r  <= '0;
          quo_r  <= neg_if(A, in_signed & A[DWIDTH-1]);
          dvs_r  <= neg_if(B, in_signed & B[DWIDTH-1]);
          cnt    <= '0;
        end
        CALC: MDOut <= calc_result(func_r, a_r, b_r);
        DIVIDE: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          cnt   <= cnt + 1'b1;
          if (last_iter) MDOut <= div_result;
        end
        default: ;
      endcase
    end
  end

endmodule
